bcd_operand_entry: RTL
======================

BCD_OPERAND_ENTRY -- requirements
Module: bcd_operand_entry

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000: consecutive stable cycles before a button level is accepted.
REQ-002 SHALL have ports clk  input  1  rising-edge system clock.
REQ-003 SHALL have ports reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have KEY_digit_n, KEY_sign_n, KEY_enter_n, KEY_clear_n  input  1 each  raw active-low push-buttons, asynchronous to clk.
REQ-005 SHALL have SW  input  4  BCD digit from switches, asynchronous to clk.
REQ-006 SHALL have A  output  10  operand A in BCD: [9:8] hundreds (0-3), [7:4] tens, [3:0] units.
REQ-007 SHALL have B  output  10  operand B, same format as A.
REQ-008 SHALL have negativeA and negativeB  output  1 each  operand signs (1 = negative).
REQ-009 SHALL have key  output  1  high while in RESULT state (display shows result).
REQ-010 SHALL have go  output  1  one-cycle pulse requesting the calculation.
REQ-011 SHALL have digit_err  output  1  one-cycle pulse when a digit is rejected.
REQ-012 SHALL have state  output  2  current state: 00 ENTRY_A, 01 ENTRY_B, 10 RESULT.

Function
REQ-013 SHALL pass each button and SW through a 2-flop synchronizer.
REQ-014 SHALL keep a per-button debounced level (reset value 1) plus counter; counter increments while synchronized level differs from debounced level, clears otherwise; at DEBOUNCE_CYCLES the debounced level takes the synchronized value and the counter clears.
REQ-015 SHALL generate a one-cycle event on each 1->0 transition of a debounced level; release generates no event.
REQ-016 SHALL make the effect of a press (register update, go, digit_err) visible on outputs exactly DEBOUNCE_CYCLES+3 cycles after the raw input falls and stays low.
REQ-017 SHALL ignore glitches shorter than DEBOUNCE_CYCLES cycles.
REQ-018 SHALL resolve simultaneous events by priority clear > enter > sign > digit; only the highest-priority event acts in that cycle, others discarded.
REQ-019 Digit event in ENTRY_A/ENTRY_B SHALL sample synchronized SW; accepted iff SW <= 9 and current tens digit <= 3; on accept operand <= {tens[1:0], units, SW} (left shift-in).
REQ-020 A rejected digit SHALL leave the operand unchanged and pulse digit_err for one cycle.
REQ-021 Digit and sign events in RESULT SHALL be ignored without digit_err.
REQ-022 Sign event SHALL toggle the sign of the operand being entered, including when its value is zero.
REQ-023 Enter SHALL move ENTRY_A->ENTRY_B, ENTRY_B->RESULT, RESULT->ENTRY_A.
REQ-024 Entering RESULT SHALL pulse go for exactly one cycle, concurrent with key going to 1.
REQ-025 RESULT->ENTRY_A via enter or clear SHALL zero A, B, negativeA, negativeB in the same cycle.
REQ-026 Clear in ENTRY_A/ENTRY_B SHALL zero the operand being entered and its sign only; state unchanged.
REQ-027 A, B and signs SHALL hold their values in RESULT.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 Reset SHALL take effect on the first rising clk edge where it is high and SHALL override all events.
REQ-030 After reset: state=ENTRY_A, A=B=0, negativeA=negativeB=0, key=0, go=0, digit_err=0, debounced levels=1, counters=0, synchronizers=1.
REQ-031 Reset asserted mid-debounce SHALL discard the pending press; no event SHALL fire for a button held across reset release until it is released and pressed again.

Verification (DEBOUNCE_CYCLES=4)
REQ-032 SW=1,2,3 each with clean digit press -> A=10'h123 once each digit lands, 7 cycles after its raw fall.
REQ-033 A=10'h045, SW=6 press -> A=10'h056; then SW=7 press (tens=5) -> A unchanged, digit_err one-cycle pulse; SW=4'hA press -> digit_err, A unchanged.
REQ-034 KEY_digit_n low for 3 cycles then high -> no A change, no digit_err.
REQ-035 Enter, enter from ENTRY_A with A=10'h012, B=10'h007, sign pressed during B -> state 01 then 10, go single pulse with key rising, negativeB=1, A/B held; third enter -> state 00, A=B=0, signs 0.
REQ-036 Clear and enter falling in the same cycle in ENTRY_B with B=10'h099 -> B=0, state stays 01, no go.
REQ-037 Reset asserted 2 cycles into a held enter press, released while held -> state 00, no transition until button released and re-pressed.

Source files
------------

// File: rtl/bcd_operand_entry.sv
// Two-operand BCD entry controller: debounces four push-buttons, shifts BCD digits
// into the operand being entered, toggles signs, and steps ENTRY_A -> ENTRY_B -> RESULT.
module bcd_operand_entry #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       KEY_digit_n,
   input  logic       KEY_sign_n,
   input  logic       KEY_enter_n,
   input  logic       KEY_clear_n,
   input  logic [3:0] SW,
   output logic [9:0] A,
   output logic [9:0] B,
   output logic       negativeA,
   output logic       negativeB,
   output logic       key,
   output logic       go,
   output logic       digit_err,
   output logic [1:0] state
);

   localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

   // Button index order: 0 digit, 1 sign, 2 enter, 3 clear (clear has top priority).
   localparam int unsigned BtnDigit = 0;
   localparam int unsigned BtnSign  = 1;
   localparam int unsigned BtnEnter = 2;
   localparam int unsigned BtnClear = 3;

   typedef enum logic [1:0] {
      StEntryA = 2'b00,
      StEntryB = 2'b01,
      StResult = 2'b10
   } state_t;

   logic [3:0]      btn_raw;
   logic [3:0]      btn_s1, btn_s2;
   logic [3:0]      sw_s1, sw_s2;
   logic [3:0]      deb;
   logic [CntW-1:0] cnt [4];
   logic [3:0]      armed;
   logic [3:0]      ev;
   logic [1:0]      settle;
   logic            settled;
   state_t          st;

   logic [9:0]      cur_op;
   logic            digit_ok;
   logic [9:0]      shifted;

   assign btn_raw = {KEY_clear_n, KEY_enter_n, KEY_sign_n, KEY_digit_n};
   assign settled = (settle == 2'd2);
   assign state   = st;

   // Two-flop synchronizers plus a short post-reset settle count so that arming only
   // looks at real (not reset-forced) synchronized levels.
   always_ff @(posedge clk) begin
      if (reset) begin
         btn_s1 <= '1;
         btn_s2 <= '1;
         sw_s1  <= '1;
         sw_s2  <= '1;
         settle <= '0;
      end else begin
         btn_s1 <= btn_raw;
         btn_s2 <= btn_s1;
         sw_s1  <= SW;
         sw_s2  <= sw_s1;
         if (!settled) settle <= settle + 2'd1;
      end
   end

   // Per-button debounce; a press event fires the cycle after the debounced level falls.
   // A button is armed only once seen released after reset, so a press held across reset
   // produces nothing until it is released and pressed again.
   always_ff @(posedge clk) begin
      if (reset) begin
         deb   <= '1;
         armed <= '0;
         ev    <= '0;
         for (int i = 0; i < 4; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            ev[i] <= armed[i] & deb[i] & ~btn_s2[i] & (cnt[i] == CntLast);
            if (btn_s2[i] != deb[i]) begin
               if (cnt[i] == CntLast) begin
                  deb[i] <= btn_s2[i];
                  cnt[i] <= '0;
               end else begin
                  cnt[i] <= cnt[i] + 1'b1;
               end
            end else begin
               cnt[i] <= '0;
            end
            if (settled && btn_s2[i]) armed[i] <= 1'b1;
         end
      end
   end

   // Digit acceptance: the current tens digit becomes hundreds, which only holds 0-3.
   always_comb begin
      cur_op   = (st == StEntryB) ? B : A;
      digit_ok = (sw_s2 <= 4'd9) && (cur_op[7:4] <= 4'd3);
      shifted  = {cur_op[5:4], cur_op[3:0], sw_s2};
   end

   // Main state machine; only the highest-priority event acts in a given cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         st        <= StEntryA;
         A         <= '0;
         B         <= '0;
         negativeA <= 1'b0;
         negativeB <= 1'b0;
         key       <= 1'b0;
         go        <= 1'b0;
         digit_err <= 1'b0;
      end else begin
         go        <= 1'b0;
         digit_err <= 1'b0;
         if (ev[BtnClear]) begin
            case (st)
               StEntryA: begin
                  A         <= '0;
                  negativeA <= 1'b0;
               end
               StEntryB: begin
                  B         <= '0;
                  negativeB <= 1'b0;
               end
               default: begin
                  st        <= StEntryA;
                  key       <= 1'b0;
                  A         <= '0;
                  B         <= '0;
                  negativeA <= 1'b0;
                  negativeB <= 1'b0;
               end
            endcase
         end else if (ev[BtnEnter]) begin
            case (st)
               StEntryA: st <= StEntryB;
               StEntryB: begin
                  st  <= StResult;
                  key <= 1'b1;
                  go  <= 1'b1;
               end
               default: begin
                  st        <= StEntryA;
                  key       <= 1'b0;
                  A         <= '0;
                  B         <= '0;
                  negativeA <= 1'b0;
                  negativeB <= 1'b0;
               end
            endcase
         end else if (ev[BtnSign]) begin
            if (st == StEntryA) negativeA <= ~negativeA;
            else if (st == StEntryB) negativeB <= ~negativeB;
         end else if (ev[BtnDigit] && (st != StResult)) begin
            if (!digit_ok) digit_err <= 1'b1;
            else if (st == StEntryA) A <= shifted;
            else B <= shifted;
         end
      end
   end

endmodule
